// File: rtl/cpu_cycle_sequencer.sv
// Multicycle FETCH/EXEC1/EXEC2 sequencer for the MIPS core. It issues bus requests,
// stalls on waitrequest or mult/div, counts retired instructions and parks on halt.
module cpu_cycle_sequencer #(
   parameter logic [31:0] HALT_ADDR   = 32'h00000000,
   parameter int          COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            pc_address,
   input  logic                   mem_waitrequest,
   input  logic                   mem_access,
   input  logic                   mem_is_write,
   input  logic                   needs_exec2,
   input  logic                   writes_reg,
   input  logic                   muldiv_busy,
   output logic                   fetch,
   output logic                   exec1,
   output logic                   exec2,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   ir_load,
   output logic                   pc_update,
   output logic                   reg_write_en,
   output logic                   active,
   output logic [COUNT_WIDTH-1:0] retired_count
);

   typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALTED} state_t;

   state_t state, state_d;
   logic   retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= FETCH;
         retired_count <= '0;
         active        <= 1'b1;
      end else begin
         state  <= state_d;
         active <= (state_d != HALTED);
         if (retire)
            retired_count <= retired_count + COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_d      = state;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_load      = 1'b0;
      pc_update    = 1'b0;
      reg_write_en = 1'b0;
      retire       = 1'b0;
      case (state)
         FETCH: begin
            if (pc_address == HALT_ADDR) begin
               state_d = HALTED;
            end else begin
               mem_read = 1'b1;
               if (!mem_waitrequest) begin
                  ir_load = 1'b1;
                  state_d = EXEC1;
               end
            end
         end
         EXEC1: begin
            mem_read  = mem_access & ~mem_is_write;
            mem_write = mem_access & mem_is_write;
            if (!((mem_access & mem_waitrequest) | muldiv_busy)) begin
               if (needs_exec2) begin
                  state_d = EXEC2;
               end else begin
                  pc_update    = 1'b1;
                  reg_write_en = writes_reg;
                  retire       = 1'b1;
                  state_d      = FETCH;
               end
            end
         end
         EXEC2: begin
            pc_update    = 1'b1;
            reg_write_en = writes_reg;
            retire       = 1'b1;
            state_d      = FETCH;
         end
         default: state_d = HALTED;
      endcase
      // Reset aborts any in-flight request or pulse in the same cycle.
      if (reset) begin
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         ir_load      = 1'b0;
         pc_update    = 1'b0;
         reg_write_en = 1'b0;
         retire       = 1'b0;
      end
   end

   assign fetch = (state == FETCH);
   assign exec1 = (state == EXEC1);
   assign exec2 = (state == EXEC2);

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed-vector scoreboard bench for cpu_cycle_sequencer (COUNT_WIDTH=4 so wrap is reachable).
module tb_cpu_cycle_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_address;
   logic        mem_waitrequest, mem_access, mem_is_write, needs_exec2, writes_reg, muldiv_busy;
   logic        fetch, exec1, exec2, mem_read, mem_write, ir_load, pc_update, reg_write_en, active;
   logic [3:0]  retired_count;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      string      name;
      logic [8:0] flags;
      logic [3:0] cnt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   cpu_cycle_sequencer #(.HALT_ADDR(32'h00000000), .COUNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .pc_address(pc_address),
      .mem_waitrequest(mem_waitrequest), .mem_access(mem_access),
      .mem_is_write(mem_is_write), .needs_exec2(needs_exec2),
      .writes_reg(writes_reg), .muldiv_busy(muldiv_busy),
      .fetch(fetch), .exec1(exec1), .exec2(exec2),
      .mem_read(mem_read), .mem_write(mem_write), .ir_load(ir_load),
      .pc_update(pc_update), .reg_write_en(reg_write_en), .active(active),
      .retired_count(retired_count)
   );

   // Monitor: flags are {fetch,exec1,exec2,mem_read,mem_write,ir_load,pc_update,reg_write_en,active}
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t       e;
         logic [8:0] got;
         e   = sb.pop_front();
         got = {fetch, exec1, exec2, mem_read, mem_write, ir_load, pc_update, reg_write_en, active};
         tests++;
         if (got !== e.flags || retired_count !== e.cnt || (mem_read & mem_write) !== 1'b0) begin
            failed++;
            $display("FAIL %s: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                     e.name, got, retired_count, e.flags, e.cnt);
         end
      end
   end

   // Drive one cycle of inputs; push the hand-computed expected outputs for that cycle.
   task automatic step(input string nm, input logic rst, input logic [31:0] pc,
                       input logic wt, input logic acc, input logic isw, input logic nx2,
                       input logic wreg, input logic busy, input logic chk,
                       input logic [8:0] ef, input logic [3:0] ec);
      exp_t e;
      reset = rst; pc_address = pc; mem_waitrequest = wt; mem_access = acc;
      mem_is_write = isw; needs_exec2 = nx2; writes_reg = wreg; muldiv_busy = busy;
      if (chk) begin
         e.name = nm; e.flags = ef; e.cnt = ec;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] PC = 32'hBFC00000;

   initial begin
      // reset
      step("rst0", 1, PC, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 4'd0);
      step("rst_state", 1, PC, 1, 1, 0, 0, 1, 1, 1, 9'b100000001, 4'd0);
      // 1: ADDU
      step("addu_fetch", 0, PC, 0, 0, 0, 0, 1, 0, 1, 9'b100101001, 4'd0);
      step("addu_exec1", 0, PC, 0, 0, 0, 0, 1, 0, 1, 9'b010000111, 4'd0);
      // 2: LW with 2 fetch waits, 1 exec1 wait
      step("lw_fetch_w1", 0, PC+4, 1, 1, 0, 1, 1, 0, 1, 9'b100100001, 4'd1);
      step("lw_fetch_w2", 0, PC+4, 1, 1, 0, 1, 1, 0, 1, 9'b100100001, 4'd1);
      step("lw_fetch_go", 0, PC+4, 0, 1, 0, 1, 1, 0, 1, 9'b100101001, 4'd1);
      step("lw_exec1_w",  0, PC+4, 1, 1, 0, 1, 1, 0, 1, 9'b010100001, 4'd1);
      step("lw_exec1_go", 0, PC+4, 0, 1, 0, 1, 1, 0, 1, 9'b010100001, 4'd1);
      step("lw_exec2",    0, PC+4, 1, 1, 0, 1, 1, 0, 1, 9'b001000111, 4'd1);
      // 3: SW
      step("sw_fetch", 0, PC+8, 0, 1, 1, 0, 0, 0, 1, 9'b100101001, 4'd2);
      step("sw_exec1", 0, PC+8, 0, 1, 1, 0, 0, 0, 1, 9'b010010101, 4'd2);
      // 6: ADDUs through the 4-bit wrap (3 -> 15 -> 0 -> 1)
      for (int i = 0; i < 14; i++) begin
         step("wrap_fetch", 0, PC+12, 0, 0, 0, 0, 1, 0, 1, 9'b100101001, 4'(3 + i));
         step("wrap_exec1", 0, PC+12, 0, 0, 0, 0, 1, 0, 1, 9'b010000111, 4'(3 + i));
      end
      step("wrap_after", 0, PC+16, 1, 0, 0, 0, 0, 0, 1, 9'b100100001, 4'd1);
      // 5: reset mid EXEC1 stall with a held read request
      step("st_fetch", 0, PC+16, 0, 1, 0, 1, 1, 1, 1, 9'b100101001, 4'd1);
      step("st_exec1", 0, PC+16, 1, 1, 0, 1, 1, 1, 1, 9'b010100001, 4'd1);
      step("st_rst",   1, PC+16, 1, 1, 0, 1, 1, 1, 1, 9'b010000001, 4'd1);
      step("st_after", 1, PC+16, 0, 1, 0, 1, 1, 1, 1, 9'b100000001, 4'd0);
      step("one_fetch", 0, PC, 0, 0, 0, 0, 1, 0, 1, 9'b100101001, 4'd0);
      step("one_exec1", 0, PC, 0, 0, 0, 0, 1, 0, 1, 9'b010000111, 4'd0);
      // 4: halt and stay parked
      step("halt_fetch", 0, 32'h0, 0, 1, 0, 1, 1, 0, 1, 9'b100000001, 4'd1);
      for (int i = 0; i < 50; i++) begin
         logic [5:0] r;
         r = 6'($urandom);
         step("halted", 0, PC + 32'(i), r[0], r[1], r[2], r[3], r[4], r[5], 1, 9'b000000000, 4'd1);
      end
      step("halt_rst",   1, PC, 0, 0, 0, 0, 1, 0, 1, 9'b000000000, 4'd1);
      step("halt_exit",  0, PC, 0, 0, 0, 0, 1, 0, 1, 9'b100101001, 4'd0);
      step("exit_exec1", 0, PC, 0, 0, 0, 0, 1, 0, 1, 9'b010000111, 4'd0);
      @(negedge clk);
      #1;
      tests++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
